// File: rtl/modular_inverse_pkg.sv
// rtl/modular_inverse_pkg.sv - shared types and sizing helpers for the modular inverse unit
package modinv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } modinv_state_t;

    // Worst-case number of RUN cycles for a w-bit modulus.
    function automatic int max_run_cycles(input int w);
        return 4 * w + 2;
    endfunction

    function automatic int cycle_cnt_width(input int w);
        return $clog2(max_run_cycles(w) + 6);
    endfunction

endpackage

// File: rtl/modular_inverse_if.sv
// rtl/modular_inverse_if.sv - start/done request bus of the modular inverse unit
// MODINV_CYCLE_COUNT_EN adds the cycles result signal.
interface modular_inverse_if
    import modinv_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] modulant;
    logic                  busy;
    logic                  done;
    logic                  ok;
    logic [DATA_WIDTH-1:0] out;
`ifdef MODINV_CYCLE_COUNT_EN
    logic [cycle_cnt_width(DATA_WIDTH)-1:0] cycles;

    modport master (output start, a, modulant, input busy, done, ok, out, cycles);
    modport slave  (input start, a, modulant, output busy, done, ok, out, cycles);
`else
    modport master (output start, a, modulant, input busy, done, ok, out);
    modport slave  (input start, a, modulant, output busy, done, ok, out);
`endif

endinterface

// File: rtl/modular_inverse_mod_halve.sv
// rtl/modular_inverse_mod_halve.sv - combinational x/2 mod m for odd m and x in [0, m-1]
module mod_halve #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH:0]   x,
    input  logic [DATA_WIDTH-1:0] m,
    output logic [DATA_WIDTH:0]   y
);
    logic [DATA_WIDTH:0] sum;

    // An odd x becomes even after adding the odd modulus; x + m < 2m fits in DATA_WIDTH+1 bits.
    always_comb begin
        sum = x[0] ? (x + {1'b0, m}) : x;
        y   = sum >> 1;
    end

endmodule

// File: rtl/modular_inverse.sv
// rtl/modular_inverse.sv - binary extended Euclid modular inverse, one step per clock
// Optional MODINV_CYCLE_COUNT_EN drives a RUN-cycle counter on bus.cycles.
module modular_inverse
    import modinv_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    modular_inverse_if.slave bus
);
    localparam int W = DATA_WIDTH;

    modinv_state_t state_q, state_d;
    logic [W-1:0]  m_q, m_d;
    logic [W-1:0]  u_q, u_d;
    logic [W-1:0]  v_q, v_d;
    logic [W:0]    x1_q, x1_d;
    logic [W:0]    x2_q, x2_d;
    logic [W-1:0]  out_q, out_d;
    logic          ok_q, ok_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [W:0]    x1_half, x2_half;
    logic [W:0]    x1_sub, x2_sub;
    logic          illegal;

    mod_halve #(.DATA_WIDTH(W)) u_halve_x1 (.x(x1_q), .m(m_q), .y(x1_half));
    mod_halve #(.DATA_WIDTH(W)) u_halve_x2 (.x(x2_q), .m(m_q), .y(x2_half));

    // Both coefficients live in [0, m-1], so one conditional add of m restores a negative difference.
    always_comb begin
        x1_sub = (x1_q >= x2_q) ? (x1_q - x2_q) : (x1_q + {1'b0, m_q} - x2_q);
        x2_sub = (x2_q >= x1_q) ? (x2_q - x1_q) : (x2_q + {1'b0, m_q} - x1_q);
    end

    assign illegal = !bus.modulant[0] || (bus.modulant <= W'(1)) ||
                     (bus.a >= bus.modulant) || (bus.a == '0);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        out_d   = out_q;
        ok_d    = ok_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ok_d  = 1'b0;
                    out_d = '0;
                    if (illegal) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        m_d     = bus.modulant;
                        u_d     = bus.a;
                        v_d     = bus.modulant;
                        x1_d    = (W+1)'(1);
                        x2_d    = '0;
                    end
                end
            end
            RUN: begin
                if (u_q == W'(1)) begin
                    out_d   = x1_q[W-1:0];
                    ok_d    = 1'b1;
                    state_d = DONE;
                end else if (v_q == W'(1)) begin
                    out_d   = x2_q[W-1:0];
                    ok_d    = 1'b1;
                    state_d = DONE;
                end else if ((u_q == '0) || (v_q == '0)) begin
                    // A zero operand before reaching 1 means gcd(a, m) > 1.
                    out_d   = '0;
                    ok_d    = 1'b0;
                    state_d = DONE;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = x1_sub;
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = x2_sub;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            out_q   <= '0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            out_q   <= out_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ok   = ok_q;
    assign bus.out  = out_q;

`ifdef MODINV_CYCLE_COUNT_EN
    localparam int CW = cycle_cnt_width(W);

    logic [CW-1:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == IDLE) && bus.start) begin
            cyc_d = '0;
        end else if (state_q == RUN) begin
            cyc_d = cyc_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.cycles = cyc_q;
`endif

endmodule

// File: tb/tb_modular_inverse.sv
// tb/tb_modular_inverse.sv - directed and randomized checks of modular_inverse against a brute-force model
module tb_modular_inverse;
    import modinv_pkg::*;

    localparam int W       = 8;
    localparam int MAX_RUN = max_run_cycles(W);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    modular_inverse_if #(.DATA_WIDTH(W)) bus ();

    modular_inverse #(.DATA_WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: legality from the input rules, inverse by exhaustive search of a*i mod m.
    function automatic void ref_inv(input int ai, input int mi,
                                    output bit legal, output bit eok, output int eout);
        legal = (mi % 2 == 1) && (mi > 1) && (ai < mi) && (ai != 0);
        eok   = 1'b0;
        eout  = 0;
        if (legal) begin
            for (int i = 1; i < mi; i++) begin
                if ((ai * i) % mi == 1) begin
                    eok  = 1'b1;
                    eout = i;
                    break;
                end
            end
        end
    endfunction

    // lat = clock edges after the start-sampling edge until done is seen (-1 on timeout).
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] mi,
                          output logic rok, output logic [W-1:0] rout, output int lat);
        bus.a        = ai;
        bus.modulant = mi;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 0; k <= MAX_RUN + 2; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        rok  = bus.ok;
        rout = bus.out;
        @(posedge clk); #1;
    endtask

    task automatic check_run(input string tag, input int ai, input int mi, input int exp_lat);
        bit           legal, eok;
        int           eout;
        logic         rok;
        logic [W-1:0] rout;
        int           lat;
        ref_inv(ai, mi, legal, eok, eout);
        run_op(W'(ai), W'(mi), rok, rout, lat);
        check({tag, "_ok"}, 32'(rok), 32'(eok));
        check({tag, "_out"}, 32'(rout), 32'(eout));
        if (!legal) begin
            check({tag, "_lat"}, lat, 0);
        end else if (exp_lat >= 0) begin
            check({tag, "_lat"}, lat, exp_lat);
        end else begin
            check({tag, "_lat_bound"}, 32'(lat >= 1 && lat <= MAX_RUN), 1);
        end
        check({tag, "_held"}, {bus.busy, bus.ok, bus.out}, {1'b0, eok, W'(eout)});
`ifdef MODINV_CYCLE_COUNT_EN
        check({tag, "_cycles"}, 32'(bus.cycles), lat);
`endif
    endtask

    initial begin
        bit seen;
        int mr, ar;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.modulant = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.busy, bus.done, bus.ok, bus.out}, '0);
`ifdef MODINV_CYCLE_COUNT_EN
        check("reset_cycles", 32'(bus.cycles), 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        check_run("m13_a3", 3, 13, -1);
        check_run("m11_a7", 7, 11, -1);
        check_run("m251_a1", 1, 251, 1);
        check_run("m15_a6", 6, 15, -1);
        check_run("m13_a0", 0, 13, -1);
        check_run("m12_a5", 5, 12, -1);
        check_run("m13_a20", 20, 13, -1);
        check_run("m1_a0", 0, 1, -1);
        check_run("m255_a254", 254, 255, -1);

        // start held high while busy, with different operands, must not disturb the first request
        bus.a        = 3;
        bus.modulant = 13;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.a        = 5;
        bus.modulant = 11;
        seen = 1'b0;
        for (int k = 0; k <= MAX_RUN + 2; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("busy_start_done", 32'(seen), 1);
        check("busy_start_ok", 32'(bus.ok), 1);
        check("busy_start_out", 32'(bus.out), 9);
        @(posedge clk); #1;
        check("busy_start_idle", 32'(bus.busy), 0);

        // reset in the middle of a run aborts it silently
        bus.a        = 200;
        bus.modulant = 251;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("midrun_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrun_reset_outputs", {bus.busy, bus.done, bus.ok, bus.out}, '0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (MAX_RUN + 4) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("midrun_no_done", 32'(seen), 0);
        check_run("after_reset", 3, 13, -1);

        // exhaustive over small odd moduli
        for (int m = 3; m < 32; m += 2) begin
            for (int a = 1; a < m; a++) begin
                check_run($sformatf("ex_m%0d_a%0d", m, a), a, m, -1);
            end
        end

        // randomized: mostly legal odd moduli, occasionally unrestricted operands
        for (int i = 0; i < 300; i++) begin
            if (i % 8 == 7) begin
                mr = int'($urandom_range(255, 0));
                ar = int'($urandom_range(255, 0));
            end else begin
                mr = 2 * int'($urandom_range(127, 1)) + 1;
                ar = int'($urandom_range(mr - 1, 1));
            end
            check_run($sformatf("rnd_m%0d_a%0d", mr, ar), ar, mr, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
